// File: rtl/vga_scanout.sv
// 640x480 VGA raster generator for the frame-buffer read side. Presents read coordinates and
// delays blank/sync by the buffer read latency so colour and sync reach the pins together.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned RD_LAT   = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic [9:0] vgaX,
    output logic [9:0] vgaY,
    output logic       rd_valid,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output logic [7:0] oRed,
    output logic [7:0] oGreen,
    output logic [7:0] oBlue,
    output logic       oHS,
    output logic       oVS,
    output logic       oBLANK_n,
    output logic       oFrameStart
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HActive  = 10'(H_ACTIVE);
    localparam logic [9:0] HSyncOn  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncOff = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VActive  = 10'(V_ACTIVE);
    localparam logic [9:0] VSyncOn  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncOff = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } tap_t;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       active;
    tap_t       cur_tap;
    tap_t       tap_out;
    tap_t [RD_LAT-1:0] dly_q, dly_d;

    logic [7:0] red_q, green_q, blue_q;
    logic       hs_q, vs_q, blank_n_q, frame_start_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        active        = (h_cnt_q < HActive) && (v_cnt_q < VActive);
        cur_tap.active = active;
        cur_tap.hs    = (h_cnt_q >= HSyncOn) && (h_cnt_q < HSyncOff);
        cur_tap.vs    = (v_cnt_q >= VSyncOn) && (v_cnt_q < VSyncOff);
        cur_tap.first = (h_cnt_q == '0) && (v_cnt_q == '0);
        dly_d         = dly_q;
        dly_d[0]      = cur_tap;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Last tap lines up with the buffer data returned for the same address.
    assign tap_out  = dly_q[RD_LAT-1];

    assign vgaX     = active ? h_cnt_q : '0;
    assign vgaY     = active ? v_cnt_q : '0;
    assign rd_valid = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            dly_q         <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (pix_ce) begin
                h_cnt_q       <= h_cnt_d;
                v_cnt_q       <= v_cnt_d;
                dly_q         <= dly_d;
                red_q         <= tap_out.active ? iRed   : '0;
                green_q       <= tap_out.active ? iGreen : '0;
                blue_q        <= tap_out.active ? iBlue  : '0;
                blank_n_q     <= tap_out.active;
                hs_q          <= tap_out.hs ? SYNC_POL : ~SYNC_POL;
                vs_q          <= tap_out.vs ? SYNC_POL : ~SYNC_POL;
                frame_start_q <= tap_out.first;
            end
        end
    end

    assign oRed        = red_q;
    assign oGreen      = green_q;
    assign oBlue       = blue_q;
    assign oHS         = hs_q;
    assign oVS         = vs_q;
    assign oBLANK_n    = blank_n_q;
    assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (read latency 1 and 3) on a shrunken raster, each fed by
// a pipelined buffer model and checked against a scoreboard of expected pixels.
module tb_vga_scanout;
    localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
    localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    typedef logic [27:0] item_t;  // {frame_start, blank_n, hs, vs, rgb}
    localparam item_t RST_ITEM = {1'b0, 1'b0, 1'b1, 1'b1, 24'h0};

    logic clk = 1'b0, reset = 1'b1, pix_ce = 1'b0, fill_ff = 1'b0, half = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] vx1, vy1, vx3, vy3;
    logic       rv1, rv3, hs1, hs3, vs1, vs3, bl1, bl3, fs1, fs3;
    logic [7:0] ir1, ig1, ib1, ir3, ig3, ib3, or1, og1, ob1, or3, og3, ob3;

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                  .V_SYNC(VS), .V_BP(VB), .RD_LAT(1), .SYNC_POL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .vgaX(vx1), .vgaY(vy1), .rd_valid(rv1),
        .iRed(ir1), .iGreen(ig1), .iBlue(ib1), .oRed(or1), .oGreen(og1), .oBlue(ob1),
        .oHS(hs1), .oVS(vs1), .oBLANK_n(bl1), .oFrameStart(fs1)
    );

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                  .V_SYNC(VS), .V_BP(VB), .RD_LAT(3), .SYNC_POL(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .vgaX(vx3), .vgaY(vy3), .rd_valid(rv3),
        .iRed(ir3), .iGreen(ig3), .iBlue(ib3), .oRed(or3), .oGreen(og3), .oBlue(ob3),
        .oHS(hs3), .oVS(vs3), .oBLANK_n(bl3), .oFrameStart(fs3)
    );

    // Frame buffer models: fixed latency in pixel ticks, data = {x, y, A5}.
    logic [23:0] buf1_q;
    logic [23:0] buf3_q [3];
    always @(posedge clk) begin
        if (pix_ce) begin
            buf1_q    <= fill_ff ? 24'hFFFFFF : {vx1[7:0], vy1[7:0], 8'hA5};
            buf3_q[0] <= fill_ff ? 24'hFFFFFF : {vx3[7:0], vy3[7:0], 8'hA5};
            buf3_q[1] <= buf3_q[0];
            buf3_q[2] <= buf3_q[1];
        end
    end
    assign {ir1, ig1, ib1} = buf1_q;
    assign {ir3, ig3, ib3} = buf3_q[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t expect_px(input int h, input int v, input logic ff);
        logic        act;
        logic [23:0] rgb;
        act = (h < int'(HA)) && (v < int'(VA));
        rgb = !act ? 24'h0 : (ff ? 24'hFFFFFF : {8'(h), 8'(v), 8'hA5});
        return {(h == 0 && v == 0), act,
                !(h >= int'(HA + HF) && h < int'(HA + HF + HS)),
                !(v >= int'(VA + VF) && v < int'(VA + VF + VS)), rgb};
    endfunction

    // Raster model and scoreboard push side.
    int    bh = 0, bv = 0;
    logic  chk_en = 1'b0;
    item_t q1[$], q3[$];
    item_t last1 = RST_ITEM, last3 = RST_ITEM;
    always @(posedge clk) begin
        if (reset) begin
            bh = 0;
            bv = 0;
            q1.delete();
            q3.delete();
            last1  = RST_ITEM;
            last3  = RST_ITEM;
            chk_en = 1'b1;
        end else if (pix_ce) begin
            q1.push_back(expect_px(bh, bv, fill_ff));
            q3.push_back(expect_px(bh, bv, fill_ff));
            bh++;
            if (bh == int'(HT)) begin
                bh = 0;
                bv++;
                if (bv == int'(VT)) bv = 0;
            end
        end
    end

    // Scoreboard pop side; on non-tick clocks outputs must hold and frame start must be low.
    always @(negedge clk) begin
        logic        act;
        logic [20:0] exp_addr;
        if (chk_en) begin
            if (q1.size() > 1) last1 = q1.pop_front();
            if (q3.size() > 3) last3 = q3.pop_front();
            check("pix_lat1", 64'({fs1, bl1, hs1, vs1, or1, og1, ob1}), 64'(last1));
            check("pix_lat3", 64'({fs3, bl3, hs3, vs3, or3, og3, ob3}), 64'(last3));
            last1[27] = 1'b0;
            last3[27] = 1'b0;
            act      = (bh < int'(HA)) && (bv < int'(VA));
            exp_addr = act ? {1'b1, 10'(bh), 10'(bv)} : 21'h0;
            check("addr_lat1", 64'({rv1, vx1, vy1}), 64'(exp_addr));
            check("addr_lat3", 64'({rv3, vx3, vy3}), 64'(exp_addr));
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
        if (half) pix_ce = ~pix_ce;
    endtask

    task automatic wait_fs(input int budget, output int clks);
        clks = 0;
        do begin
            tick1();
            clks++;
        end while (!fs1 && clks < budget);
    endtask

    initial begin
        int n, n1, n3, hs_lo, vs_lo, fs_cnt, blank_leak;
        reset  = 1'b1;
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        check("rst_addr", 64'({rv1, vx1, vy1}), 64'({1'b1, 20'h0}));
        check("rst_outs", 64'({fs1, bl1, hs1, vs1, or1}), 64'({4'b0011, 8'h00}));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Full rate: frame period and sync widths.
        wait_fs(2 * FRAME, n);
        check("first_fs_full", 64'(n), 64'(2));
        hs_lo  = 0;
        vs_lo  = 0;
        fs_cnt = 0;
        for (int i = 1; i <= int'(FRAME); i++) begin
            tick1();
            if (!hs1) hs_lo++;
            if (!vs1) vs_lo++;
            if (fs1) fs_cnt++;
            if (i == 1) check("fs_width_full", 64'(fs1), 64'(0));
        end
        check("frame_period_full", 64'(fs1), 64'(1));
        check("fs_per_frame", 64'(fs_cnt), 64'(1));
        check("hs_low_ticks", 64'(hs_lo), 64'(VT * HS));
        check("vs_low_ticks", 64'(vs_lo), 64'(VS * HT));

        // Constant white data must never leak into blanking.
        fill_ff    = 1'b1;
        blank_leak = 0;
        for (int i = 0; i < int'(FRAME) + 4; i++) begin
            tick1();
            if (!bl1 && {or1, og1, ob1} != 24'h0) blank_leak++;
            if (!bl3 && {or3, og3, ob3} != 24'h0) blank_leak++;
        end
        check("blank_leak", 64'(blank_leak), 64'(0));
        fill_ff = 1'b0;

        // Half-rate pixel tick.
        half = 1'b1;
        wait_fs(4 * FRAME, n);
        tick1();
        check("fs_width_half", 64'(fs1), 64'(0));
        wait_fs(4 * FRAME, n);
        check("frame_period_half", 64'(n + 1), 64'(2 * FRAME));
        half = 1'b0;
        pix_ce = 1'b1;

        // Reset mid-frame inside vertical sync.
        n = 0;
        while (!(bh == 20 && bv == 9) && n < 2 * int'(FRAME)) begin
            tick1();
            n++;
        end
        check("reach_vsync", 64'({10'(bh), 10'(bv), vs1}), 64'({10'd20, 10'd9, 1'b0}));
        reset = 1'b1;
        tick1();
        check("midrst_lat1", 64'({hs1, vs1, bl1, vx1, vy1}), 64'({3'b110, 20'h0}));
        check("midrst_lat3", 64'({hs3, vs3, bl3, vx3, vy3}), 64'({3'b110, 20'h0}));
        reset = 1'b0;
        n1 = 0;
        n3 = 0;
        for (int i = 1; i <= 10; i++) begin
            tick1();
            if (fs1 && n1 == 0) n1 = i;
            if (fs3 && n3 == 0) n3 = i;
        end
        check("fs_after_rst_lat1", 64'(n1), 64'(2));
        check("fs_after_rst_lat3", 64'(n3), 64'(4));

        repeat (int'(FRAME)) tick1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
